// File: rtl/adc_pkg.sv
// Shared types and default parameters for the ADC scan sequencer.
package adc_pkg;

  localparam int unsigned DefNumCh         = 4;
  localparam int unsigned DefWidth         = 3;
  localparam int unsigned DefSettleCycles  = 2;
  localparam int unsigned DefTimeoutCycles = 16;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StConvert,
    StDone
  } adc_seq_state_t;

endpackage

// File: rtl/adc_scan_sequencer_if.sv
// Channel request/ack, SAR control and result bus of the scan sequencer.
interface adc_scan_sequencer_if
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH = DefNumCh,
  parameter int unsigned WIDTH  = DefWidth
);
  localparam int unsigned SelW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              seq_en;
  logic [NUM_CH-1:0] ch_req;
  logic [NUM_CH-1:0] ch_ack;
  logic [SelW-1:0]   ch_sel;
  logic              adc_en;
  logic              eoc_n;
  logic              load_reg;
  logic [WIDTH-1:0]  reg_wdata;
  logic              res_valid;
  logic [SelW-1:0]   res_ch;
  logic [WIDTH-1:0]  res_data;
  logic              res_err;
  logic              busy;

  modport master (
    input  seq_en, ch_req, eoc_n, load_reg, reg_wdata,
    output ch_ack, ch_sel, adc_en, res_valid, res_ch, res_data, res_err, busy
  );

  modport slave (
    output seq_en, ch_req, eoc_n, load_reg, reg_wdata,
    input  ch_ack, ch_sel, adc_en, res_valid, res_ch, res_data, res_err, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter; the pointer holds the last granted channel.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned IdxW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              gnt_en_i,
  output logic [NUM_CH-1:0] gnt_o,
  output logic [IdxW-1:0]   gnt_idx_o
);

  logic [IdxW-1:0] ptr_q, ptr_d;

  // Search starts one past the last grant so every requester is served in turn.
  always_comb begin
    int unsigned c;
    c         = 0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      c = (32'(ptr_q) + i) % NUM_CH;
      if (gnt_o == '0 && req_i[c[IdxW-1:0]]) begin
        gnt_o[c[IdxW-1:0]] = 1'b1;
        gnt_idx_o          = c[IdxW-1:0];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_en_i && (gnt_o != '0)) begin
      ptr_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IdxW'(NUM_CH - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Scans requesting channels through one shared SAR converter: settle, convert, report.
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int unsigned NUM_CH         = DefNumCh,
  parameter int unsigned WIDTH          = DefWidth,
  parameter int unsigned SETTLE_CYCLES  = DefSettleCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input logic                  clk,
  input logic                  rst,
  adc_scan_sequencer_if.master bus_io
);

  localparam int unsigned SelW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CntMax = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                    : SETTLE_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  adc_seq_state_t    state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  buf_q, buf_d;
  logic [SelW-1:0]   ch_sel_q, ch_sel_d;
  logic [NUM_CH-1:0] ch_ack_q, ch_ack_d;
  logic              adc_en_q, adc_en_d;
  logic              res_valid_q, res_valid_d;
  logic [SelW-1:0]   res_ch_q, res_ch_d;
  logic [WIDTH-1:0]  res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              busy_q, busy_d;

  logic [NUM_CH-1:0] gnt;
  logic [SelW-1:0]   gnt_idx;
  logic              gnt_en, grant, settle_last, conv_timeout;

  assign gnt_en       = (state_q == StIdle) && bus_io.seq_en;
  assign grant        = gnt_en && (gnt != '0);
  assign settle_last  = (cnt_q == CntW'(SETTLE_CYCLES - 1));
  assign conv_timeout = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .req_i    (bus_io.ch_req),
    .gnt_en_i (gnt_en),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StSettle;
          cnt_d   = '0;
        end
      end
      StSettle: begin
        if (settle_last) begin
          state_d = StConvert;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StConvert: begin
        if (!bus_io.eoc_n || conv_timeout) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed one cycle ahead so every port comes straight from a flop.
  always_comb begin
    ch_sel_d    = ch_sel_q;
    buf_d       = buf_q;
    res_ch_d    = res_ch_q;
    res_data_d  = res_data_q;
    res_err_d   = res_err_q;
    res_valid_d = 1'b0;
    ch_ack_d    = '0;
    adc_en_d    = (state_d == StConvert);
    busy_d      = (state_d != StIdle);
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          ch_sel_d = gnt_idx;
          buf_d    = '0;
        end
      end
      StConvert: begin
        if (bus_io.load_reg) begin
          buf_d = bus_io.reg_wdata;
        end
        if (state_d == StDone) begin
          res_valid_d = 1'b1;
          res_ch_d    = ch_sel_q;
          ch_ack_d    = NUM_CH'(1) << ch_sel_q;
          res_err_d   = bus_io.eoc_n;
          // A same-cycle load wins over the buffered value; a timeout reports zero.
          res_data_d  = bus_io.eoc_n ? '0 : (bus_io.load_reg ? bus_io.reg_wdata : buf_q);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      buf_q       <= '0;
      ch_sel_q    <= '0;
      ch_ack_q    <= '0;
      adc_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      ch_sel_q    <= ch_sel_d;
      ch_ack_q    <= ch_ack_d;
      adc_en_q    <= adc_en_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus_io.ch_sel    = ch_sel_q;
  assign bus_io.ch_ack    = ch_ack_q;
  assign bus_io.adc_en    = adc_en_q;
  assign bus_io.res_valid = res_valid_q;
  assign bus_io.res_ch    = res_ch_q;
  assign bus_io.res_data  = res_data_q;
  assign bus_io.res_err   = res_err_q;
  assign bus_io.busy      = busy_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: directed table, reset/seq_en corners, random scans.
module tb_adc_scan_sequencer;

  localparam int unsigned NCh    = 4;
  localparam int unsigned W      = 3;
  localparam int unsigned Settle = 2;
  localparam int unsigned Tmo    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_scan_sequencer_if #(.NUM_CH(NCh), .WIDTH(W)) bus ();

  adc_scan_sequencer #(
    .NUM_CH        (NCh),
    .WIDTH         (W),
    .SETTLE_CYCLES (Settle),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus.master)
  );

  typedef struct {
    bit         rst_first;
    logic [3:0] req;
    int         eoc_at;   // CONVERT cycle with eoc_n=0; out of range means timeout
    int         ld_a;
    logic [2:0] va;
    int         ld_b;     // later load, overrides ld_a
    logic [2:0] vb;
    bit         drop_req;
    int         exp_ch;
    logic [2:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t  vecs[11];
  int    checks   = 0;
  int    failures = 0;
  int    last_gnt = 3;
  string cur      = "init";

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s actual=%0h required=%0h", cur, name, act, exp);
    end
  endtask

  function automatic int rr_pick(input int last, input logic [3:0] req);
    for (int i = 1; i <= int'(NCh); i++) begin
      if (req[(last + i) % NCh]) return (last + i) % NCh;
    end
    return -1;
  endfunction

  // Result of one conversion from the SAR activity the bench drives.
  task automatic model_result(input int eoc_at, input int ld_a, input logic [2:0] va,
                              input int ld_b, input logic [2:0] vb,
                              output logic [2:0] data, output logic err);
    int e;
    err  = !(eoc_at >= 0 && eoc_at < int'(Tmo));
    e    = err ? int'(Tmo) - 1 : eoc_at;
    data = '0;
    for (int k = 0; k <= e; k++) begin
      if (k == ld_a) data = va;
      if (k == ld_b) data = vb;
    end
    if (err) data = '0;
  endtask

  task automatic do_reset();
    bus.ch_req   = '0;
    bus.seq_en   = 1'b0;
    bus.eoc_n    = 1'b1;
    bus.load_reg = 1'b0;
    bus.reg_wdata = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last_gnt = 3;
  endtask

  task automatic conv(input logic [3:0] req, input int eoc_at, input int ld_a,
                      input logic [2:0] va, input int ld_b, input logic [2:0] vb,
                      input bit drop_req, input bit drop_en, input int exp_ch,
                      input logic [2:0] exp_data, input logic exp_err);
    int         n;
    int         k;
    int         e;
    logic [3:0] ack_exp;
    e       = (eoc_at >= 0 && eoc_at < int'(Tmo)) ? eoc_at : int'(Tmo) - 1;
    ack_exp = 4'b0001 << exp_ch;
    bus.ch_req = req;
    bus.seq_en = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!bus.busy && n < 8);
    chk("grant_busy", bus.busy, 1);
    chk("grant_ch", bus.ch_sel, exp_ch);
    chk("grant_adc_low", bus.adc_en, 0);
    if (drop_req) bus.ch_req = '0;
    if (drop_en) bus.seq_en = 1'b0;
    n = 0;
    while (!bus.adc_en && n < 10) begin
      step();
      n++;
    end
    chk("settle_len", n, Settle);
    k = 0;
    while (!bus.res_valid && k < 40) begin
      bus.load_reg  = (k == ld_a) || (k == ld_b);
      bus.reg_wdata = (k == ld_b) ? vb : ((k == ld_a) ? va : 3'($urandom));
      bus.eoc_n     = (k == eoc_at) ? 1'b0 : 1'b1;
      step();
      k++;
      if (!bus.res_valid) chk("conv_sel_stable", bus.ch_sel, exp_ch);
    end
    chk("conv_len", k, e + 1);
    chk("done_valid", bus.res_valid, 1);
    chk("done_ch", bus.res_ch, exp_ch);
    chk("done_data", bus.res_data, exp_data);
    chk("done_err", bus.res_err, exp_err);
    chk("done_ack", bus.ch_ack, ack_exp);
    chk("done_adc_low", bus.adc_en, 0);
    chk("done_sel", bus.ch_sel, exp_ch);
    // SAR activity outside CONVERT must be ignored.
    bus.load_reg  = 1'b1;
    bus.reg_wdata = 3'b111;
    bus.eoc_n     = 1'b0;
    step();
    chk("idle_valid", bus.res_valid, 0);
    chk("idle_ack", bus.ch_ack, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_adc_low", bus.adc_en, 0);
    chk("hold_data", bus.res_data, exp_data);
    chk("hold_ch", bus.res_ch, exp_ch);
    chk("hold_err", bus.res_err, exp_err);
    bus.load_reg = 1'b0;
    bus.eoc_n    = 1'b1;
    last_gnt     = exp_ch;
  endtask

  initial begin
    logic [3:0] req;
    int         eoc_at, ld_a, ld_b, ech;
    logic [2:0] va, vb, edata;
    logic       eerr;
    bit         dreq;

    //          rst  req      eoc  lda va      ldb vb      drop ch data    err
    vecs[0]  = '{1, 4'b0100,   3,  1, 3'd5,    -1, 3'd0,   0,   2, 3'd5,   1'b0};
    vecs[1]  = '{0, 4'b1111,   0,  0, 3'd3,    -1, 3'd0,   0,   3, 3'd3,   1'b0};
    vecs[2]  = '{0, 4'b0010,  -1,  2, 3'd7,    -1, 3'd0,   0,   1, 3'd0,   1'b1};
    vecs[3]  = '{0, 4'b0001,   5, -1, 3'd0,    -1, 3'd0,   0,   0, 3'd0,   1'b0};
    vecs[4]  = '{0, 4'b1000,   4,  1, 3'd6,     3, 3'd2,   1,   3, 3'd2,   1'b0};
    vecs[5]  = '{0, 4'b0110,  15, 15, 3'd4,    -1, 3'd0,   0,   1, 3'd4,   1'b0};
    vecs[6]  = '{1, 4'b1111,   2,  1, 3'd1,    -1, 3'd0,   0,   0, 3'd1,   1'b0};
    vecs[7]  = '{0, 4'b1111,   1,  0, 3'd2,    -1, 3'd0,   0,   1, 3'd2,   1'b0};
    vecs[8]  = '{0, 4'b1111,   0, -1, 3'd0,    -1, 3'd0,   0,   2, 3'd0,   1'b0};
    vecs[9]  = '{0, 4'b1111,   3,  2, 3'd7,    -1, 3'd0,   0,   3, 3'd7,   1'b0};
    vecs[10] = '{0, 4'b1111,   2,  2, 3'd5,    -1, 3'd0,   0,   0, 3'd5,   1'b0};

    do_reset();
    cur = "reset";
    chk("adc_en", bus.adc_en, 0);
    chk("busy", bus.busy, 0);
    chk("ch_sel", bus.ch_sel, 0);
    chk("ch_ack", bus.ch_ack, 0);
    chk("res_valid", bus.res_valid, 0);
    chk("res_ch", bus.res_ch, 0);
    chk("res_data", bus.res_data, 0);
    chk("res_err", bus.res_err, 0);

    foreach (vecs[i]) begin
      cur = $sformatf("vec%0d", i);
      if (vecs[i].rst_first) do_reset();
      conv(vecs[i].req, vecs[i].eoc_at, vecs[i].ld_a, vecs[i].va, vecs[i].ld_b, vecs[i].vb,
           vecs[i].drop_req, 1'b0, vecs[i].exp_ch, vecs[i].exp_data, vecs[i].exp_err);
    end

    // Reset in the middle of CONVERT aborts silently.
    cur = "rst_mid";
    bus.ch_req = 4'b0100;
    bus.seq_en = 1'b1;
    begin
      int n = 0;
      while (!bus.adc_en && n < 10) begin
        step();
        n++;
      end
    end
    chk("reach_convert", bus.adc_en, 1);
    step();
    step();
    rst = 1'b1;
    bus.ch_req = '0;
    bus.seq_en = 1'b0;
    step();
    chk("adc_en", bus.adc_en, 0);
    chk("busy", bus.busy, 0);
    chk("res_valid", bus.res_valid, 0);
    chk("ch_ack", bus.ch_ack, 0);
    chk("ch_sel", bus.ch_sel, 0);
    chk("res_data", bus.res_data, 0);
    rst = 1'b0;
    bus.eoc_n    = 1'b0;
    bus.load_reg = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_valid", bus.res_valid, 0);
      chk("post_ack", bus.ch_ack, 0);
    end
    bus.eoc_n    = 1'b1;
    bus.load_reg = 1'b0;
    last_gnt     = 3;
    conv(4'b1111, 1, 0, 3'd6, -1, 3'd0, 1'b0, 1'b0, 0, 3'd6, 1'b0);

    // seq_en dropped during SETTLE: conversion finishes, next grant waits.
    cur = "seq_en_drop";
    conv(4'b0011, 2, 1, 3'd3, -1, 3'd0, 1'b0, 1'b1, 1, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("blocked_busy", bus.busy, 0);
      chk("blocked_adc", bus.adc_en, 0);
    end
    conv(4'b0011, 0, -1, 3'd0, -1, 3'd0, 1'b0, 1'b0, 0, 3'd0, 1'b0);

    // Random scans against the transaction model.
    for (int t = 0; t < 30; t++) begin
      cur    = $sformatf("rand%0d", t);
      req    = 4'($urandom_range(1, 15));
      eoc_at = int'($urandom_range(0, 19));
      ld_a   = int'($urandom_range(0, 17)) - 1;
      ld_b   = (ld_a >= 0 && $urandom_range(0, 1) == 1) ? ld_a + int'($urandom_range(1, 5)) : -1;
      va     = 3'($urandom);
      vb     = 3'($urandom);
      dreq   = ($urandom_range(0, 3) == 0);
      ech    = rr_pick(last_gnt, req);
      model_result(eoc_at, ld_a, va, ld_b, vb, edata, eerr);
      conv(req, eoc_at, ld_a, va, ld_b, vb, dreq, 1'b0, ech, edata, eerr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
